// File: rtl/alu_operand_stage_if.sv
// Operand data port for alu_operand_stage: word plus valid/ready handshake.
// Upstream drives the master side; the stage is the slave.
interface alu_operand_stage_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Sequential operand fetch / result capture around a combinational 16-bit ALU.
// Define ALU_STAGE_DIVZERO_EN to saturate divide-by-zero and raise div_err.
module alu_operand_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            oc_in,
  alu_operand_stage_if.slave    dport,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic                  div_err
);

  localparam logic [2:0] OC_DIV = 3'b011;
  localparam logic [2:0] OC_NOT = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            oc_q, oc_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;
`ifdef ALU_STAGE_DIVZERO_EN
  logic                  dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    oc_d    = oc_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
`ifdef ALU_STAGE_DIVZERO_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          oc_d    = oc_in;
          state_d = LOAD_A;
`ifdef ALU_STAGE_DIVZERO_EN
          dz_d    = 1'b0;
`endif
        end
      end
      LOAD_A: begin
        if (dport.din_valid) begin
          a_d     = dport.din;
          state_d = (oc_q == OC_NOT) ? EXEC : LOAD_B;
        end
      end
      LOAD_B: begin
        if (dport.din_valid) begin
          b_d     = dport.din;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_f;
        zero_d  = (alu_f == '0);
        neg_d   = alu_f[DATA_WIDTH-1];
`ifdef ALU_STAGE_DIVZERO_EN
        // Saturate instead of trusting the ALU's divide-by-zero output
        if (oc_q == OC_DIV && b_q == '0) begin
          res_d  = '1;
          zero_d = 1'b0;
          neg_d  = 1'b1;
          dz_d   = 1'b1;
        end
`endif
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      oc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      oc_q    <= oc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

`ifdef ALU_STAGE_DIVZERO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end

  assign div_err = dz_q;
`else
  assign div_err = 1'b0;
`endif

  assign dport.din_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign alu_oc  = oc_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign result  = res_q;
  assign zero    = zero_q;
  assign neg     = neg_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed and random ops against an
// arithmetic reference, with a behavioural ALU closing the loop.
module tb_alu_operand_stage;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    oc_in = 3'd0;
  logic [2:0]    alu_oc;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_f;
  logic [W-1:0]  result;
  logic          zero;
  logic          neg;
  logic          busy;
  logic          done;
  logic          div_err;

  alu_operand_stage_if #(.DATA_WIDTH(W)) dif ();

  alu_operand_stage #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .oc_in   (oc_in),
    .dport   (dif),
    .alu_oc  (alu_oc),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_f   (alu_f),
    .result  (result),
    .zero    (zero),
    .neg     (neg),
    .busy    (busy),
    .done    (done),
    .div_err (div_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_model(
    input logic [2:0] oc, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] f;
    case (oc)
      3'd0: f = a + b;
      3'd1: f = a - b;
      3'd2: f = a * b;
      3'd3: f = (b == '0) ? '0 : a / b;
      3'd4: f = ~a;
      3'd5: f = a ^ b;
      3'd6: f = a & b;
      default: f = a | b;
    endcase
    return f;
  endfunction

  assign alu_f = alu_model(alu_oc, alu_a, alu_b);

  function automatic logic [W-1:0] exp_result(
    input logic [2:0] oc, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ia, ib, r;
    logic [W-1:0] v;
    ia = longint'(a);
    ib = longint'(b);
    r  = 0;
    case (oc)
      3'd0: r = (ia + ib) % 65536;
      3'd1: r = (ia - ib + 65536) % 65536;
      3'd2: r = (ia * ib) % 65536;
      3'd3: begin
        if (ib == 0) begin
`ifdef ALU_STAGE_DIVZERO_EN
          r = 65535;
`else
          r = 0;
`endif
        end else begin
          r = ia / ib;
        end
      end
      3'd4: r = 65535 - ia;
      default: r = 0;
    endcase
    v = r[W-1:0];
    if (oc == 3'd5) v = a ^ b;
    if (oc == 3'd6) v = a & b;
    if (oc == 3'd7) v = a | b;
    return v;
  endfunction

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_b = '0;
  logic         m_dz = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op from an IDLE negedge; return at the first IDLE negedge after.
  task automatic run_op(input logic [2:0] oc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int sa, input int sb,
                        input bit poke);
    int cnt, phase, nphase, lat, ra, rb;
    bit unary;
    logic [W-1:0] er;
    unary = (oc == 3'd4);
    ra = sa;
    rb = sb;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", dif.din_ready, 0);
    chk("idle_diverr", div_err, m_dz);
    start = 1'b1;
    oc_in = oc;
    dif.din_valid = ($urandom_range(0, 1) == 1);
    dif.din = W'($urandom);
    @(negedge clk);
    start = 1'b0;
    m_dz = 1'b0;
    cnt = 1;
    phase = 0;
    chk("start_diverr_clr", div_err, 0);
    while (phase != 3 && cnt <= 40) begin
      chk("busy", busy, 1);
      chk("ready", dif.din_ready, (phase < 2));
      chk("done_early", done, 0);
      nphase = phase;
      start = (poke && ($urandom_range(0, 1) == 1));
      if (phase == 0) begin
        if (ra > 0) begin
          dif.din_valid = 1'b0;
          dif.din = W'($urandom);
          ra--;
        end else begin
          dif.din_valid = 1'b1;
          dif.din = a;
          nphase = unary ? 2 : 1;
        end
      end else if (phase == 1) begin
        if (rb > 0) begin
          dif.din_valid = 1'b0;
          dif.din = W'($urandom);
          rb--;
        end else begin
          dif.din_valid = 1'b1;
          dif.din = b;
          nphase = 2;
        end
      end else begin
        dif.din_valid = ($urandom_range(0, 1) == 1);
        dif.din = W'($urandom);
        nphase = 3;
      end
      @(negedge clk);
      cnt++;
      phase = nphase;
    end
    start = 1'b0;
    dif.din_valid = 1'b0;
    lat = unary ? (3 + sa) : (4 + sa + sb);
    chk("latency", cnt, lat);
    if (!unary) m_b = b;
    er = exp_result(oc, a, m_b);
`ifdef ALU_STAGE_DIVZERO_EN
    m_dz = (oc == 3'd3) && (m_b == '0);
`endif
    chk("done", done, 1);
    chk("done_busy", busy, 1);
    chk("result", result, er);
    chk("zero", zero, (er == '0));
    chk("neg", neg, er[W-1]);
    chk("alu_oc", alu_oc, oc);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, m_b);
    chk("div_err", div_err, m_dz);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    dif.din = '0;
    dif.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", dif.din_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, neg, div_err}, 0);
    chk("rst_alu", {alu_oc, alu_a, alu_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 16'h0005, 16'h0003, 0, 0, 1'b0);
    run_op(3'd1, 16'h0000, 16'h0001, 0, 0, 1'b0);
    run_op(3'd5, 16'h00FF, 16'h00FF, 0, 0, 1'b0);
    run_op(3'd4, 16'h00F0, 16'h1234, 0, 0, 1'b0);
    run_op(3'd2, 16'h0100, 16'h0100, 5, 0, 1'b1);
    run_op(3'd3, 16'h0010, 16'h0000, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("diverr_held", div_err, m_dz);
    run_op(3'd3, 16'h0010, 16'h0004, 0, 2, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [2:0] roc;
      logic [W-1:0] rbv;
      roc = 3'($urandom_range(0, 7));
      rbv = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      run_op(roc, W'($urandom), rbv, $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
    end

    start = 1'b1;
    oc_in = 3'd0;
    @(negedge clk);
    start = 1'b0;
    dif.din_valid = 1'b1;
    dif.din = 16'h1234;
    @(negedge clk);
    chk("midop_in_load_b", dif.din_ready, 1);
    dif.din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midop_busy", busy, 0);
    chk("midop_ready", dif.din_ready, 0);
    chk("midop_result", result, 0);
    chk("midop_alu_a", alu_a, 0);
    @(negedge clk);
    chk("midop_busy_next", busy, 0);
    rst_n = 1'b1;
    m_b = '0;
    m_dz = 1'b0;
    dif.din_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midop_no_done", {busy, done}, 0);
    end
    dif.din_valid = 1'b0;
    run_op(3'd0, 16'h7FFF, 16'h0001, 1, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
